// File: rtl/sprite_pixel_fetch.sv
// Sprite-ROM requester: maps VGA pixel coordinates onto a 32x32 glyph ROM and
// composites the returned colour over the background with a fixed 2-cycle latency.
module sprite_pixel_fetch #(
    parameter int unsigned SCALE_SHIFT  = 0,
    parameter logic [11:0] TRANSPARENT  = 12'hFFF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [9:0]  pos_x_in,
    input  logic [9:0]  pos_y_in,
    input  logic        vis_in,
    input  logic        pos_valid,
    input  logic        blink_en,
    input  logic [11:0] bg_rgb,
    output logic [4:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb,
    output logic        sprite_hit
);

    localparam int unsigned CntW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_FRAMES - 1);
    localparam logic [10:0] BoxSize = 11'(32 << SCALE_SHIFT);

    typedef enum logic {StShow, StHide} blink_state_e;

    // Staging and active (displayed) sprite registers
    logic [9:0]  stg_x_q, stg_y_q, act_x_q, act_y_q;
    logic        stg_vis_q, act_vis_q;
    logic        pending_q, pending_d;
    logic        commit;

    // Blink timer
    blink_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            blink_phase;

    // Hit test and pipeline
    logic [10:0] dx, dy;
    logic        in_box;
    logic        hit1_d, hit1_q, von1_q;
    logic [11:0] bg1_q;
    logic [11:0] rgb_d, rgb_q;
    logic        sprite_hit_d, sprite_hit_q;

    always_comb begin
        dx      = {1'b0, x} - {1'b0, act_x_q};
        dy      = {1'b0, y} - {1'b0, act_y_q};
        in_box  = (x >= act_x_q) & (y >= act_y_q) & (dx < BoxSize) & (dy < BoxSize);
        rom_row = in_box ? 5'(dy >> SCALE_SHIFT) : 5'd0;
        rom_col = in_box ? 5'(dx >> SCALE_SHIFT) : 5'd0;
    end

    // A commit coincident with a new strobe takes the old staging; the new value stays pending.
    always_comb begin
        commit    = frame_tick & pending_q;
        pending_d = pending_q;
        if (commit) pending_d = 1'b0;
        if (pos_valid) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_x_q   <= '0;
            stg_y_q   <= '0;
            stg_vis_q <= 1'b0;
            act_x_q   <= '0;
            act_y_q   <= '0;
            act_vis_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (commit) begin
                act_x_q   <= stg_x_q;
                act_y_q   <= stg_y_q;
                act_vis_q <= stg_vis_q;
            end
            if (pos_valid) begin
                stg_x_q   <= pos_x_in;
                stg_y_q   <= pos_y_in;
                stg_vis_q <= vis_in;
            end
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blink_phase = (state_q == StHide);
        if (!blink_en) begin
            state_d = StShow;
            cnt_d   = '0;
        end else if (frame_tick) begin
            if (cnt_q == CntMax) begin
                cnt_d   = '0;
                state_d = (state_q == StShow) ? StHide : StShow;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StShow;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        hit1_d       = in_box & act_vis_q & ~(blink_en & blink_phase) & video_on;
        rgb_d        = bg1_q;
        sprite_hit_d = 1'b0;
        if (!von1_q) begin
            rgb_d = '0;
        end else if (hit1_q && (rom_color != TRANSPARENT)) begin
            rgb_d        = rom_color;
            sprite_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit1_q       <= 1'b0;
            von1_q       <= 1'b0;
            bg1_q        <= '0;
            rgb_q        <= '0;
            sprite_hit_q <= 1'b0;
        end else begin
            hit1_q       <= hit1_d;
            von1_q       <= video_on;
            bg1_q        <= bg_rgb;
            rgb_q        <= rgb_d;
            sprite_hit_q <= sprite_hit_d;
        end
    end

    assign rgb        = rgb_q;
    assign sprite_hit = sprite_hit_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch: two instances (1x and 2x scale) share stimulus and are
// checked against a frame-level reference model plus directed address vectors.
module tb_sprite_pixel_fetch;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y, pos_x_in, pos_y_in;
    logic        video_on, frame_tick, vis_in, pos_valid, blink_en;
    logic [11:0] bg_rgb;
    logic [4:0]  rom_row0, rom_col0, rom_row1, rom_col1;
    logic [11:0] rom_color0, rom_color1, rgb0, rgb1;
    logic        hit_s0, hit_s1;

    always #5 clk = ~clk;

    sprite_pixel_fetch #(.SCALE_SHIFT(0), .TRANSPARENT(12'hFFF), .BLINK_FRAMES(BF)) dut0 (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .vis_in(vis_in), .pos_valid(pos_valid), .blink_en(blink_en), .bg_rgb(bg_rgb),
        .rom_row(rom_row0), .rom_col(rom_col0), .rom_color(rom_color0),
        .rgb(rgb0), .sprite_hit(hit_s0)
    );

    sprite_pixel_fetch #(.SCALE_SHIFT(1), .TRANSPARENT(12'hFFF), .BLINK_FRAMES(BF)) dut1 (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .vis_in(vis_in), .pos_valid(pos_valid), .blink_en(blink_en), .bg_rgb(bg_rgb),
        .rom_row(rom_row1), .rom_col(rom_col1), .rom_color(rom_color1),
        .rgb(rgb1), .sprite_hit(hit_s1)
    );

    // Glyph ROM contents selectable per test; mode 0 and 2 are never transparent.
    int rom_mode;
    function automatic logic [11:0] rom_fn(input int mode, input logic [4:0] r,
                                           input logic [4:0] c);
        case (mode)
            0:       return {r, c, 2'b01};
            1:       return 12'hFFF;
            2:       return 12'h000;
            default: return (r[0] ^ c[0]) ? 12'hFFF : {c, r, 2'b10};
        endcase
    endfunction

    always @(posedge clk) begin
        rom_color0 <= rom_fn(rom_mode, rom_row0, rom_col0);
        rom_color1 <= rom_fn(rom_mode, rom_row1, rom_col1);
    end

    typedef struct {
        logic [11:0] rgb;
        logic        hit;
    } exp_t;

    typedef struct {
        int px, py;
        int r0, c0, r1, c1;
    } vec_t;

    exp_t q0[$], q1[$];
    int   errs = 0, checks = 0;

    // Reference state: staged/active sprite and frames elapsed since blink enabled
    int m_sx, m_sy, m_ax, m_ay, m_ticks;
    bit m_sv, m_av, m_pend;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0; m_ticks = 0;
        m_sv = 0; m_av = 0; m_pend = 0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{rgb: 12'h0, hit: 1'b0});
            q1.push_back('{rgb: 12'h0, hit: 1'b0});
        end
    endtask

    task automatic model_addr(input int s, output bit inb, output int r, output int c);
        int dx, dy;
        dx  = int'(x) - m_ax;
        dy  = int'(y) - m_ay;
        inb = (dx >= 0) && (dy >= 0) && (dx < (32 << s)) && (dy < (32 << s));
        r   = inb ? (dy >> s) : 0;
        c   = inb ? (dx >> s) : 0;
    endtask

    // One pixel clock: check outputs from two cycles ago and this cycle's ROM address.
    task automatic step();
        exp_t        e;
        bit          ib, h, phase;
        int          r, c;
        logic [11:0] rc;
        #1;
        e = q0.pop_front();
        check("rgb_s0", rgb0, e.rgb);
        check("hit_s0", hit_s0, e.hit);
        e = q1.pop_front();
        check("rgb_s1", rgb1, e.rgb);
        check("hit_s1", hit_s1, e.hit);
        phase = ((m_ticks / BF) % 2) == 1;
        for (int s = 0; s < 2; s++) begin
            model_addr(s, ib, r, c);
            if (s == 0) begin
                check("rom_row_s0", rom_row0, r);
                check("rom_col_s0", rom_col0, c);
            end else begin
                check("rom_row_s1", rom_row1, r);
                check("rom_col_s1", rom_col1, c);
            end
            h      = ib && m_av && !(blink_en && phase) && video_on;
            rc     = rom_fn(rom_mode, 5'(r), 5'(c));
            e.hit  = video_on && h && (rc != 12'hFFF);
            e.rgb  = !video_on ? 12'h0 : (e.hit ? rc : bg_rgb);
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        if (frame_tick && m_pend) begin
            m_ax = m_sx; m_ay = m_sy; m_av = m_sv; m_pend = 0;
        end
        if (pos_valid) begin
            m_sx = int'(pos_x_in); m_sy = int'(pos_y_in); m_sv = vis_in; m_pend = 1;
        end
        if (!blink_en)       m_ticks = 0;
        else if (frame_tick) m_ticks++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rgb_s0", rgb0, 12'h0);
        check("reset_hit_s0", hit_s0, 1'b0);
        check("reset_rgb_s1", rgb1, 12'h0);
        check("reset_hit_s1", hit_s1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic place(input int px, input int py, input bit vis);
        pos_x_in = 10'(px); pos_y_in = 10'(py); vis_in = vis; pos_valid = 1'b1;
        video_on = 1'b0;
        step();
        pos_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1; video_on = 1'b0;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pix_hit(input int px, input int py, output logic h);
        x = 10'(px); y = 10'(py); video_on = 1'b1;
        step();
        video_on = 1'b0;
        step();
        #1;
        h = hit_s0;
    endtask

    task automatic chk_addr(input string nm, input int px, input int py, input int r,
                            input int c);
        x = 10'(px); y = 10'(py); video_on = 1'b1;
        #1;
        check({nm, "_row"}, rom_row0, r);
        check({nm, "_col"}, rom_col0, c);
        step();
    endtask

    vec_t tbl[8];
    logic h;

    initial begin
        tbl[0] = '{px: 101, py: 51,  r0: 1,  c0: 1,  r1: 0,  c1: 0};
        tbl[1] = '{px: 99,  py: 51,  r0: 0,  c0: 0,  r1: 0,  c1: 0};
        tbl[2] = '{px: 131, py: 81,  r0: 31, c0: 31, r1: 15, c1: 15};
        tbl[3] = '{px: 132, py: 51,  r0: 0,  c0: 0,  r1: 0,  c1: 16};
        tbl[4] = '{px: 163, py: 113, r0: 0,  c0: 0,  r1: 31, c1: 31};
        tbl[5] = '{px: 164, py: 113, r0: 0,  c0: 0,  r1: 0,  c1: 0};
        tbl[6] = '{px: 100, py: 49,  r0: 0,  c0: 0,  r1: 0,  c1: 0};
        tbl[7] = '{px: 120, py: 70,  r0: 20, c0: 20, r1: 10, c1: 10};

        x = '0; y = '0; video_on = 0; frame_tick = 0; pos_x_in = '0; pos_y_in = '0;
        vis_in = 0; pos_valid = 0; blink_en = 0; bg_rgb = 12'h5A5; rom_mode = 2;
        do_reset();

        // Basic blit and scaled addressing
        place(100, 50, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            x = 10'(tbl[i].px); y = 10'(tbl[i].py); video_on = 1'b1;
            #1;
            check("tbl_row_s0", rom_row0, tbl[i].r0);
            check("tbl_col_s0", rom_col0, tbl[i].c0);
            check("tbl_row_s1", rom_row1, tbl[i].r1);
            check("tbl_col_s1", rom_col1, tbl[i].c1);
            step();
        end
        pix_hit(101, 51, h);
        check("blit_hit", h, 1'b1);
        check("blit_rgb", rgb0, 12'h000);
        pix_hit(99, 51, h);
        check("blit_miss_hit", h, 1'b0);
        check("blit_miss_rgb", rgb0, 12'h5A5);

        // Transparency
        rom_mode = 1;
        pix_hit(110, 60, h);
        check("transp_hit", h, 1'b0);
        check("transp_rgb", rgb0, 12'h5A5);
        rom_mode = 2;

        // Right-edge clipping, no wrap
        place(620, 0, 1);
        tick();
        x = 10'd639; y = 10'd0; video_on = 1'b1;
        #1;
        check("clip_col_s0", rom_col0, 19);
        check("clip_col_s1", rom_col1, 9);
        step();
        pix_hit(0, 0, h);
        check("clip_nowrap", h, 1'b0);

        // Double buffering, including a strobe coincident with the commit
        place(100, 50, 1);
        tick();
        place(200, 200, 1);
        chk_addr("db_old", 110, 60, 10, 10);
        pos_x_in = 10'd300; pos_y_in = 10'd300; vis_in = 1'b1; pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        chk_addr("db_commit", 210, 210, 10, 10);
        chk_addr("db_staged", 310, 310, 0, 0);
        tick();
        chk_addr("db_next", 310, 310, 10, 10);

        // Blink: shown 2 ticks, hidden 2, shown again; dropping enable reveals at once
        blink_en = 1'b1;
        step();
        pix_hit(310, 310, h); check("blink_0", h, 1'b1);
        tick(); pix_hit(310, 310, h); check("blink_1", h, 1'b1);
        tick(); pix_hit(310, 310, h); check("blink_2", h, 1'b0);
        tick(); pix_hit(310, 310, h); check("blink_3", h, 1'b0);
        tick(); pix_hit(310, 310, h); check("blink_4", h, 1'b1);
        tick(); tick();
        pix_hit(310, 310, h); check("blink_6", h, 1'b0);
        blink_en = 1'b0;
        pix_hit(310, 310, h); check("blink_off", h, 1'b1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            int tx, ty;
            tx = m_ax + int'($urandom_range(0, 80)) - 8;
            ty = m_ay + int'($urandom_range(0, 80)) - 8;
            if (tx < 0) tx = 0;
            if (ty < 0) ty = 0;
            if (tx > 1023) tx = 1023;
            if (ty > 1023) ty = 1023;
            x = 10'(tx); y = 10'(ty);
            video_on   = ($urandom_range(0, 7) != 0);
            bg_rgb     = 12'($urandom);
            frame_tick = ($urandom_range(0, 39) == 0);
            pos_valid  = ($urandom_range(0, 49) == 0);
            pos_x_in   = 10'($urandom_range(0, 639));
            pos_y_in   = 10'($urandom_range(0, 479));
            vis_in     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 19) == 0) rom_mode = int'($urandom_range(0, 3));
            step();
        end
        frame_tick = 1'b0; pos_valid = 1'b0; blink_en = 1'b0; rom_mode = 2;
        bg_rgb = 12'h5A5;

        // Reset mid-line while a sprite pixel is on the output
        place(100, 50, 1);
        tick();
        x = 10'd110; y = 10'd60; video_on = 1'b1;
        step();
        step();
        #1;
        check("pre_reset_hit", hit_s0, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rgb_s0", rgb0, 12'h0);
        check("async_hit_s0", hit_s0, 1'b0);
        check("async_rgb_s1", rgb1, 12'h0);
        check("async_hit_s1", hit_s1, 1'b0);
        video_on = 1'b0;
        do_reset();
        pix_hit(110, 60, h); check("post_reset_hidden", h, 1'b0);
        tick();
        pix_hit(110, 60, h); check("post_tick_hidden", h, 1'b0);
        place(100, 50, 1);
        tick();
        pix_hit(110, 60, h); check("post_commit_shown", h, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Requester side of the 32x32 sprite-ROM interface. The block sits between the VGA sync generator and a glyph ROM: it turns the current pixel coordinates into ROM row/col addresses, absorbs the ROM's one-cycle registered-address latency, and composites the returned 12-bit colour over a background colour. Sprite position and visibility are double-buffered and change only at frame boundaries, so there is no tearing. An optional blink timer is included.

## Interface
Parameters:
- SCALE_SHIFT, 0: magnification factor 2^SCALE_SHIFT (legal values 0..2).
- TRANSPARENT, 12'hFFF: ROM colour treated as see-through (ROM default fill).
- BLINK_FRAMES, 30: frames per blink half-period (≥1).

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  10  current pixel column from sync generator.
- y  in  10  current pixel row from sync generator.
- video_on  in  1  active-display flag aligned with x/y.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- pos_x_in  in  10  staged sprite left edge.
- pos_y_in  in  10  staged sprite top edge.
- vis_in  in  1  staged visibility.
- pos_valid  in  1  one-cycle strobe capturing pos_x_in/pos_y_in/vis_in into the staging registers.
- blink_en  in  1  enables the blink timer.
- bg_rgb  in  12  background colour aligned with x/y.
- rom_row  out  5  ROM row address (combinational).
- rom_col  out  5  ROM column address (combinational).
- rom_color  in  12  ROM data, valid one cycle after the address.
- rgb  out  12  composited pixel (registered).
- sprite_hit  out  1  registered; 1 when rgb came from an opaque sprite pixel.

## Operation
- Staging: when pos_valid=1, store pos/vis in the staging registers and set pending=1.
- Frame commit: on frame_tick with pending=1, copy staging into the active registers and clear pending. If pos_valid and frame_tick arrive in the same cycle, the commit uses the previous staging contents, the new values are staged, and pending stays 1.
- Hit test on cycle t, in 11-bit unsigned arithmetic: dx=x-act_x, dy=y-act_y. in_box = (x≥act_x) & (y≥act_y) & (dx < 32<<SCALE_SHIFT) & (dy < 32<<SCALE_SHIFT). There is no wrap: a sprite that extends past 639/479 is clipped.
- Addresses: rom_row=dy>>SCALE_SHIFT and rom_col=dx>>SCALE_SHIFT when in_box, otherwise 0.
- Stage 1 (edge ending t): register hit1 = in_box & act_vis & ~(blink_en & blink_phase) & video_on, and also register video_on1 and bg1.
- Stage 2 (edge ending t+1): if video_on1=0, rgb=0 and sprite_hit=0. If hit1 and rom_color≠TRANSPARENT, rgb=rom_color and sprite_hit=1. Otherwise rgb=bg1 and sprite_hit=0.
- Blink FSM, states SHOW (blink_phase=0) and HIDE (blink_phase=1):
  - frame_cnt increments on frame_tick while blink_en=1.
  - When frame_cnt reaches BLINK_FRAMES-1, it wraps to 0 and the state toggles.
  - blink_en=0 forces frame_cnt=0 and state SHOW on the next edge.
- Reset values, asynchronous: rgb=0, sprite_hit=0, act_x=act_y=0, act_vis=0, staging=0, pending=0, frame_cnt=0, state SHOW, and all pipeline registers 0.
- Reset mid-frame: outputs go to 0 immediately. The sprite stays hidden until a pos_valid is followed by a frame_tick.

## Timing
- Latency from x/y/video_on/bg_rgb to rgb/sprite_hit is exactly 2 cycles; the caller delays hsync/vsync by 2 to match.
- rom_row/rom_col are valid in the same cycle as x/y. The ROM registers them, so rom_color corresponds to cycle t during t+1.
- An active-register update is visible starting with the first pixel after the frame_tick edge.
- No stalls, no backpressure; one pixel per clock.

## Test plan
- Basic blit: SCALE_SHIFT=0; pos_valid with (100,50), vis=1; then frame_tick. At x=101,y=51, rom_row=1 and rom_col=1 in the same cycle. With ROM returning 12'h000, rgb=12'h000 and sprite_hit=1 two cycles later. At x=99, rgb=bg_rgb and sprite_hit=0.
- Transparency and clipping: ROM returns 12'hFFF inside the box, so rgb=bg_rgb. With pos (620,0), x=639 gives rom_col=19; x=0 gives no hit (no wrap).
- Scaling: SCALE_SHIFT=1, pos (0,0). At x=63,y=63: rom_row=31, rom_col=31, hit. At x=64: no hit, rom_col=0.
- Double buffering: pos_valid (200,200) in mid-frame leaves pixels at the old position until frame_tick. pos_valid coincident with frame_tick: the commit takes the previous staging contents, and the new value is applied at the next frame_tick.
- Blink: BLINK_FRAMES=2, blink_en=1. Sprite is shown for 2 frame_ticks, hidden for 2, then shown again. Dropping blink_en while in HIDE makes the sprite visible on the next edge.
- Reset: assert reset_n=0 mid-line with sprite_hit=1. rgb and sprite_hit must read 0 immediately, without waiting for a clock edge. After release the sprite stays hidden until a pos_valid followed by frame_tick.
